// File: rtl/adc_trig_packer_if.sv
// Write port toward one downstream FIFO: word, valid strobe, and stall back from the FIFO.
interface adc_trig_packer_if;
    logic [31:0] fifo_writedata;
    logic        fifo_write;
    logic        fifo_waitrequest;

    modport master (
        output fifo_writedata,
        output fifo_write,
        input  fifo_waitrequest
    );

    modport slave (
        input  fifo_writedata,
        input  fifo_write,
        output fifo_waitrequest
    );
endinterface

// File: rtl/adc_trig_packer.sv
// Pre-trigger ADC capture: a header plus 2-sample words per event, buffered in OBUF.
// Header reaches the bus 2 cycles after the trigger edge; waitrequest holds the output word; a full OBUF drops the trigger.
module adc_trig_packer #(
    parameter int         DATA_W     = 14,
    parameter int         PRE        = 8,
    parameter int         POST       = 24,
    parameter int         OBUF_DEPTH = 32,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     trg_in,
    input  logic                     write_en,
    input  logic                     ext_rst,
    adc_trig_packer_if.master        fifo,
    output logic                     busy,
    output logic [23:0]              evt_cnt,
    output logic [15:0]              drop_cnt
);
    localparam int WIN       = PRE + POST;
    localparam int EVT_WORDS = 1 + WIN / 2;
    localparam int PAD_W     = 16 - DATA_W;
    localparam int AW        = $clog2(OBUF_DEPTH);
    localparam int ARM_W     = $clog2(PRE + 1);
    localparam int CAP_W     = $clog2(WIN);

    localparam logic [AW:0]      ROOM_MAX = (AW+1)'(OBUF_DEPTH - EVT_WORDS);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(PRE - 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(WIN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_CAP} state_t;

    state_t             state, state_nxt;
    logic               trg_q;
    logic               trg_edge;
    logic [DATA_W-1:0]  dly [PRE];
    logic [DATA_W-1:0]  cap_smp;
    logic [DATA_W-1:0]  hold;
    logic [ARM_W-1:0]   arm_cnt;
    logic [CAP_W-1:0]   cap_cnt;
    logic               push_vld;
    logic [31:0]        push_dat;
    logic               evt_inc;
    logic               drop_inc;
    logic               room;

    logic [31:0]        mem [OBUF_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        cnt;
    logic               out_vld;
    logic [31:0]        out_dat;
    logic               pop_out;
    logic               load_out;

    assign trg_edge = trg_in & ~trg_q;
    assign room     = (cnt <= ROOM_MAX);
    assign pop_out  = out_vld & ~fifo.fifo_waitrequest;
    assign load_out = (cnt != '0) & (~out_vld | pop_out);

    assign fifo.fifo_write     = out_vld;
    assign fifo.fifo_writedata = out_dat;
    assign busy                = (state == S_CAP);

    // cap_smp lags the delay-line tap by one cycle so the first CAP cycle sees sample T-PRE
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < PRE; i++) dly[i] <= '0;
            cap_smp <= '0;
            trg_q   <= 1'b0;
        end else if (ext_rst) begin
            for (int i = 0; i < PRE; i++) dly[i] <= '0;
            cap_smp <= '0;
            trg_q   <= 1'b0;
        end else begin
            dly[0] <= adc_data;
            for (int i = 1; i < PRE; i++) dly[i] <= dly[i-1];
            cap_smp <= dly[PRE-1];
            trg_q   <= trg_in;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else if (ext_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_vld  = 1'b0;
        push_dat  = '0;
        evt_inc   = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (write_en) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!write_en)              state_nxt = S_IDLE;
                else if (arm_cnt == ARM_LAST) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!write_en) begin
                    state_nxt = S_IDLE;
                end else if (trg_edge) begin
                    if (room) begin
                        push_vld  = 1'b1;
                        push_dat  = {MAGIC, evt_cnt};
                        evt_inc   = 1'b1;
                        state_nxt = S_CAP;
                    end else begin
                        drop_inc  = 1'b1;
                    end
                end
            end
            S_CAP: begin
                // even index parks the earlier sample, odd index completes the word
                if (cap_cnt[0]) begin
                    push_vld = 1'b1;
                    push_dat = {{PAD_W{1'b0}}, cap_smp, {PAD_W{1'b0}}, hold};
                    if (cap_cnt == CAP_LAST) state_nxt = write_en ? S_WAIT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            arm_cnt  <= '0;
            cap_cnt  <= '0;
            hold     <= '0;
            evt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (ext_rst) begin
            arm_cnt  <= '0;
            cap_cnt  <= '0;
            hold     <= '0;
            evt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            arm_cnt <= (state == S_ARM) ? arm_cnt + ARM_W'(1) : '0;
            cap_cnt <= (state == S_CAP && state_nxt == S_CAP) ? cap_cnt + CAP_W'(1) : '0;
            if (state == S_CAP && !cap_cnt[0]) hold <= cap_smp;
            if (evt_inc) evt_cnt <= evt_cnt + 24'd1;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    // the output register sits in front of mem; the admission check counts mem only
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (ext_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (load_out) rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, load_out})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (load_out) begin
                out_vld <= 1'b1;
                out_dat <= mem[rd_ptr];
            end else if (pop_out) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_trig_packer.sv
// Random and directed stimulus against an event-level model of capture windows and word packing.
module tb_adc_trig_packer;
    localparam int PRE   = 8;
    localparam int POST  = 24;
    localparam int WIN   = PRE + POST;
    localparam int EW    = 1 + WIN / 2;
    localparam int DEPTH = 32;
    localparam int HN    = 8192;

    typedef struct {
        int          t;
        int          idx;
        logic [23:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] adc_data;
    logic        trg_in, write_en, ext_rst;
    logic        busy;
    logic [23:0] evt_cnt;
    logic [15:0] drop_cnt;

    adc_trig_packer_if bus();

    adc_trig_packer #(
        .DATA_W(14), .PRE(PRE), .POST(POST), .OBUF_DEPTH(DEPTH), .MAGIC(8'hA5)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .adc_data      (adc_data),
        .trg_in        (trg_in),
        .write_en      (write_en),
        .ext_rst       (ext_rst),
        .fifo          (bus),
        .busy          (busy),
        .evt_cnt       (evt_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [13:0] hist [HN];
    exp_t        expq [$];
    int          armed_from = -1;
    int          cap_start = -1;
    int          cap_end = -1;
    logic [23:0] m_evt = '0;
    logic [15:0] m_drop = '0;
    int          outstanding = 0;
    logic        m_prev_trg = 1'b0;
    bit          ramp = 1'b1;
    bit          rand_wr = 1'b0;
    int          n_xfer = 0;
    int          busy_cycles = 0;
    int          hdr_cyc = 0;
    logic [31:0] last_hdr = '0;
    logic [31:0] first_data = '0;
    logic        prev_stall = 1'b0;
    logic        prev_ext = 1'b0;
    logic [31:0] prev_dat = '0;
    int          t0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_word(exp_t e);
        int base;
        if (e.idx == 0) return {8'hA5, e.cnt};
        base = e.t - PRE + 2 * (e.idx - 1);
        return {2'b00, hist[(base + 1) % HN], 2'b00, hist[base % HN]};
    endfunction

    // Event-level reference: decides what the inputs of cycle c do, effective from cycle c+1.
    task automatic model_cycle(input int c);
        logic edge_seen;
        if (ext_rst) begin
            armed_from = -1; cap_start = -1; cap_end = -1;
            m_evt = '0; m_drop = '0; outstanding = 0; m_prev_trg = 1'b0;
            expq.delete();
            return;
        end
        edge_seen  = trg_in && !m_prev_trg;
        m_prev_trg = trg_in;
        if (c <= cap_end) begin
            if (c == cap_end && !write_en) armed_from = -1;
        end else if (armed_from < 0) begin
            if (write_en) armed_from = c + PRE + 1;
        end else if (!write_en) begin
            armed_from = -1;
        end else if (edge_seen && c >= armed_from) begin
            if (outstanding <= DEPTH + 1 - EW) begin
                for (int i = 0; i < EW; i++) expq.push_back('{t: c, idx: i, cnt: m_evt});
                m_evt       = m_evt + 24'd1;
                outstanding = outstanding + EW;
                cap_start   = c + 1;
                cap_end     = c + WIN;
            end else if (m_drop != 16'hFFFF) begin
                m_drop = m_drop + 16'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) model_cycle(cyc);
        cyc++;
        adc_data = ramp ? 14'(cyc) : 14'($urandom);
        hist[cyc % HN] = adc_data;
        if (rand_wr) bus.fifo_waitrequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic trg_pulse();
        trg_in = 1'b1;
        step();
        trg_in = 1'b0;
    endtask

    task automatic ext_pulse();
        ext_rst = 1'b1;
        step();
        ext_rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !prev_ext) begin
                chk("stall_vld", 32'(bus.fifo_write), 32'd1);
                chk("stall_dat", bus.fifo_writedata, prev_dat);
            end
            if (bus.fifo_write && !bus.fifo_waitrequest) begin
                if (expq.size() == 0) begin
                    chk("extra_word", 32'(expq.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk($sformatf("word%0d_t%0d", e.idx, e.t), bus.fifo_writedata, exp_word(e));
                    if (e.idx == 0) begin
                        last_hdr = bus.fifo_writedata;
                        hdr_cyc  = cyc;
                    end
                    if (e.idx == 1) first_data = bus.fifo_writedata;
                    outstanding--;
                end
                n_xfer++;
            end
            chk("busy", 32'(busy), 32'(cyc >= cap_start && cyc <= cap_end));
            chk("evt_cnt", 32'(evt_cnt), 32'(m_evt));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (busy) busy_cycles++;
            prev_stall = bus.fifo_write && bus.fifo_waitrequest;
            prev_ext   = ext_rst;
            prev_dat   = bus.fifo_writedata;
        end
    end

    initial begin
        rst_n = 1'b0; trg_in = 1'b0; write_en = 1'b0; ext_rst = 1'b0;
        adc_data = '0; bus.fifo_waitrequest = 1'b0;
        hist[0] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", 32'(bus.fifo_write), 32'd0);
        chk("rst_data", bus.fifo_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;

        // 1: ramp data, single event, latency and window alignment
        write_en = 1'b1; n_xfer = 0; busy_cycles = 0;
        run(20);
        t0 = cyc;
        trg_pulse();
        run(60);
        chk("t1_words", 32'(n_xfer), 32'd17);
        chk("t1_busy_len", 32'(busy_cycles), 32'd32);
        chk("t1_hdr", last_hdr, 32'hA500_0000);
        chk("t1_hdr_lat", 32'(hdr_cyc - t0), 32'd2);
        chk("t1_first", first_data, {2'b00, 14'(t0 - 7), 2'b00, 14'(t0 - 8)});

        // 2: trigger while arming is ignored
        write_en = 1'b0;
        ext_pulse();
        run(3);
        write_en = 1'b1;
        run(3);
        n_xfer = 0;
        trg_in = 1'b1; run(2); trg_in = 1'b0;
        run(40);
        chk("t2_words", 32'(n_xfer), 32'd0);
        chk("t2_evt", 32'(evt_cnt), 32'd0);
        chk("t2_drop", 32'(drop_cnt), 32'd0);

        // 3: stalled output, second event rejected for space
        bus.fifo_waitrequest = 1'b1;
        n_xfer = 0;
        trg_pulse();
        for (int i = 0; i < 39; i++) begin
            step();
            if (i % 10 == 9) begin
                chk("t3_hold_vld", 32'(bus.fifo_write), 32'd1);
                chk("t3_hold_dat", bus.fifo_writedata, 32'hA500_0000);
            end
        end
        trg_pulse();
        run(20);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_evt", 32'(evt_cnt), 32'd1);
        chk("t3_hold_end", bus.fifo_writedata, 32'hA500_0000);
        bus.fifo_waitrequest = 1'b0;
        run(60);
        chk("t3_words", 32'(n_xfer), 32'd17);
        chk("t3_idle_write", 32'(bus.fifo_write), 32'd0);

        // 4: soft clear in the middle of a capture
        trg_pulse();
        run(14);
        ext_pulse();
        chk("t4_write_off", 32'(bus.fifo_write), 32'd0);
        chk("t4_busy_off", 32'(busy), 32'd0);
        chk("t4_evt", 32'(evt_cnt), 32'd0);
        chk("t4_drop", 32'(drop_cnt), 32'd0);
        run(20);
        trg_pulse();
        run(60);
        chk("t4_hdr", last_hdr, 32'hA500_0000);

        // 5: enable dropped mid-capture completes the event, then stays idle
        n_xfer = 0;
        trg_pulse();
        run(10);
        write_en = 1'b0;
        run(40);
        chk("t5_words", 32'(n_xfer), 32'd17);
        trg_pulse();
        run(40);
        chk("t5_no_more", 32'(n_xfer), 32'd17);
        chk("t5_evt", 32'(evt_cnt), 32'd2);

        // 6: retrigger inside the capture window is ignored
        write_en = 1'b1;
        ext_pulse();
        run(20);
        n_xfer = 0;
        trg_pulse();
        run(9);
        trg_pulse();
        run(60);
        chk("t6_words", 32'(n_xfer), 32'd17);
        chk("t6_evt", 32'(evt_cnt), 32'd1);
        chk("t6_drop", 32'(drop_cnt), 32'd0);

        // random data, random stalls, random enable drops and retriggers
        ramp = 1'b0;
        rand_wr = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int gap;
            gap = $urandom_range(50, 90);
            write_en = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                write_en = 1'b0;
                run($urandom_range(3, 12));
                write_en = 1'b1;
            end
            run(12);
            trg_in = 1'b1;
            run($urandom_range(1, 3));
            trg_in = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                run($urandom_range(5, 20));
                trg_pulse();
            end
            if ($urandom_range(0, 3) == 0) begin
                run($urandom_range(2, 25));
                write_en = 1'b0;
            end
            run(gap);
        end

        rand_wr = 1'b0;
        bus.fifo_waitrequest = 1'b0;
        write_en = 1'b0;
        run(80);
        chk("final_drain", 32'(expq.size()), 32'd0);
        chk("final_write", 32'(bus.fifo_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
